tdc_initial: RTL and testbench

Power-up configuration sequencer for an external TDC-GPX-class time-to-digital converter. After reset it pulses the converter's power-on reset, waits a settle interval and writes a fixed table of 12 configuration words over the 4-bit address / 28-bit data parallel bus. It then releases the four stop-channel disables. It sits between the board reset and the TDC chip, and is idle once configuration completes.

---
 rtl/tdc_pkg.sv | 48 ++++
 rtl/tdc_initial_if.sv | 27 ++
 rtl/tdc_cfg_rom.sv | 13 +
 rtl/tdc_initial.sv | 142 ++++++++++++++
 tb/tb_tdc_initial.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC power-up configuration sequencer.
// Holds the sequencer state enum, bus widths, and the fixed table of
// configuration writes (register address + data) issued after power-up.
package tdc_pkg;

  localparam int TDC_ADDR_W     = 4;
  localparam int TDC_DATA_W     = 28;
  localparam int TDC_NUM_WRITES = 12;
  localparam int TDC_IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_PURES,
    ST_SETTLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } tdc_state_e;

  typedef struct packed {
    logic [TDC_ADDR_W-1:0] addr;
    logic [TDC_DATA_W-1:0] data;
  } tdc_cfg_t;

  // Configuration table in write order. The final entry rewrites reg 4
  // with bit 22 set, which triggers the converter's master reset so it
  // starts from the freshly loaded configuration.
  function automatic tdc_cfg_t tdc_cfg_entry(input logic [TDC_IDX_W-1:0] idx);
    tdc_cfg_t e;
    case (idx)
      4'd0:    e = '{addr: 4'd0,  data: 28'h007FC81};
      4'd1:    e = '{addr: 4'd1,  data: 28'h0000000};
      4'd2:    e = '{addr: 4'd2,  data: 28'h0000002};
      4'd3:    e = '{addr: 4'd3,  data: 28'h0000000};
      4'd4:    e = '{addr: 4'd4,  data: 28'h6000000};
      4'd5:    e = '{addr: 4'd5,  data: 28'h0000000};
      4'd6:    e = '{addr: 4'd6,  data: 28'h0000000};
      4'd7:    e = '{addr: 4'd7,  data: 28'h0001FB4};
      4'd8:    e = '{addr: 4'd11, data: 28'h7FF0000};
      4'd9:    e = '{addr: 4'd12, data: 28'h2000000};
      4'd10:   e = '{addr: 4'd14, data: 28'h0000000};
      4'd11:   e = '{addr: 4'd4,  data: 28'h6400000};
      default: e = '{addr: '0,    data: '0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/tdc_initial_if.sv
// Parallel bus from the configuration sequencer to the TDC chip.
// Handshake: none in the valid/ready sense. The sequencer owns the bus; a
// write is CSN low with addr/data stable, and the TDC latches on WRN low.
// The TDC never stalls the sequencer, so there is no back-pressure signal.
// master: sequencer side (drives everything); slave: TDC side (observes).
interface tdc_initial_if;
  import tdc_pkg::*;

  logic                  WRN;
  logic                  CSN;
  logic                  PuResN;
  logic                  StopDis1;
  logic                  StopDis2;
  logic                  StopDis3;
  logic                  StopDis4;
  logic [TDC_ADDR_W-1:0] addr;
  logic [TDC_DATA_W-1:0] data;

  modport master (
    output WRN, CSN, PuResN, StopDis1, StopDis2, StopDis3, StopDis4, addr, data
  );

  modport slave (
    input WRN, CSN, PuResN, StopDis1, StopDis2, StopDis3, StopDis4, addr, data
  );

endinterface

// File: rtl/tdc_cfg_rom.sv
// Combinational lookup of the configuration table.
// Ports: idx  - write index (0..11, higher values return zero)
//        word - {addr, data} for that write
module tdc_cfg_rom
  import tdc_pkg::*;
(
  input  logic [TDC_IDX_W-1:0] idx,
  output tdc_cfg_t             word
);

  assign word = tdc_cfg_entry(idx);

endmodule

// File: rtl/tdc_initial.sv
// Power-up configuration sequencer for a TDC-GPX-class converter.
// Pulses PuResN, waits a settle interval, writes the 12-entry config table
// (4 cycles per write: SETUP, STROBE x2, HOLD), then enables the stop
// channels and idles in DONE until the next reset.
// Ports: clk       - system clock, rising edge
//        reset_n   - synchronous active-low reset
//        bus       - TDC parallel bus (master side)
//        dbg_state - current sequencer state
module tdc_initial
  import tdc_pkg::*;
#(
  parameter int PURES_CYCLES  = 10,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tdc_initial_if.master        bus,
  output tdc_state_e           dbg_state
);

  localparam int MAX_CYC = (PURES_CYCLES > SETTLE_CYCLES) ? PURES_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 1) ? 1 : $clog2(MAX_CYC + 1);

  tdc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [TDC_IDX_W-1:0] idx_q, idx_d;
  tdc_cfg_t             rom_word;

  logic                  wrn_d, csn_d, puresn_d, stopdis_d;
  logic [TDC_ADDR_W-1:0] addr_d;
  logic [TDC_DATA_W-1:0] data_d;

  // Looked up with the next index so the registered addr/data line up with
  // the registered state.
  tdc_cfg_rom u_rom (
    .idx  (idx_d),
    .word (rom_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      ST_PURES: begin
        if (cnt_inc == CNT_W'(PURES_CYCLES)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SETTLE: begin
        if (cnt_inc == CNT_W'(SETTLE_CYCLES)) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      // Two strobe cycles: the counter marks the second one.
      ST_STROBE: begin
        if (cnt_q != '0) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (idx_q == TDC_IDX_W'(TDC_NUM_WRITES - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETUP;
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_PURES;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state and then registered, so no
  // pin sees a combinational path from the state decode.
  always_comb begin
    wrn_d     = (state_d != ST_STROBE);
    csn_d     = !((state_d == ST_SETUP) || (state_d == ST_STROBE));
    puresn_d  = (state_d != ST_PURES);
    stopdis_d = (state_d != ST_DONE);
    addr_d    = '0;
    data_d    = '0;
    if ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD)) begin
      addr_d = rom_word.addr;
      data_d = rom_word.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_PURES;
      cnt_q        <= '0;
      idx_q        <= '0;
      bus.WRN      <= 1'b1;
      bus.CSN      <= 1'b1;
      bus.PuResN   <= 1'b0;
      bus.StopDis1 <= 1'b1;
      bus.StopDis2 <= 1'b1;
      bus.StopDis3 <= 1'b1;
      bus.StopDis4 <= 1'b1;
      bus.addr     <= '0;
      bus.data     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bus.WRN      <= wrn_d;
      bus.CSN      <= csn_d;
      bus.PuResN   <= puresn_d;
      bus.StopDis1 <= stopdis_d;
      bus.StopDis2 <= stopdis_d;
      bus.StopDis3 <= stopdis_d;
      bus.StopDis4 <= stopdis_d;
      bus.addr     <= addr_d;
      bus.data     <= data_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_tdc_initial.sv
// Bench for tdc_initial: default-parameter instance plus a short-timing
// instance (PURES_CYCLES=3, SETTLE_CYCLES=2) sharing one reset.
module tb_tdc_initial;
  import tdc_pkg::*;

  localparam int P0 = 10;
  localparam int S0 = 10;
  localparam int P1 = 3;
  localparam int S1 = 2;

  // Spec write table as {addr[3:0], data[27:0]}.
  localparam logic [31:0] REF_TAB [12] = '{
    32'h0007FC81, 32'h10000000, 32'h20000002, 32'h30000000,
    32'h46000000, 32'h50000000, 32'h60000000, 32'h70001FB4,
    32'hB7FF0000, 32'hC2000000, 32'hE0000000, 32'h46400000
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  tdc_initial_if bus0 ();
  tdc_initial_if bus1 ();
  tdc_state_e dbg0, dbg1;

  tdc_initial #(.PURES_CYCLES(P0), .SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .dbg_state(dbg0)
  );
  tdc_initial #(.PURES_CYCLES(P1), .SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .dbg_state(dbg1)
  );

  logic [38:0] act0, act1;
  assign act0 = {bus0.WRN, bus0.CSN, bus0.PuResN,
                 bus0.StopDis1, bus0.StopDis2, bus0.StopDis3, bus0.StopDis4,
                 bus0.addr, bus0.data};
  assign act1 = {bus1.WRN, bus1.CSN, bus1.PuResN,
                 bus1.StopDis1, bus1.StopDis2, bus1.StopDis3, bus1.StopDis4,
                 bus1.addr, bus1.data};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [38:0] mk(input bit w, input bit c, input bit p,
                                     input logic [3:0] sd, input logic [3:0] a,
                                     input logic [27:0] d);
    return {w, c, p, sd, a, d};
  endfunction

  // ---------------- reference model ----------------
  // Expected pins after t rising edges with reset released, from the
  // timeline: PuResN low for p cycles, s idle cycles, 12 writes of 4 cycles
  // (setup, strobe, strobe, hold), then done.
  function automatic logic [38:0] model(input int t, input int p, input int s);
    bit          wrn, csn, pu;
    logic [3:0]  sd;
    logic [31:0] ad;
    int          w, ph;
    wrn = 1'b1;
    csn = 1'b1;
    pu  = (t >= p);
    sd  = 4'hF;
    ad  = 32'h0;
    if (t >= p + s + 48) begin
      sd = 4'h0;
    end else if (t >= p + s) begin
      w   = (t - p - s) / 4;
      ph  = (t - p - s) % 4;
      ad  = REF_TAB[w];
      csn = (ph == 3);
      wrn = !((ph == 1) || (ph == 2));
    end
    return {wrn, csn, pu, sd, ad};
  endfunction

  // Cycle count since reset release; every cycle both DUTs are checked.
  int t_cyc = 0;
  always @(posedge clk) begin
    if (!reset_n) t_cyc = 0;
    else if (t_cyc < 100000) t_cyc++;
    #1;
    check($sformatf("cycle_dut0_t%0d", t_cyc), act0, model(t_cyc, P0, S0));
    check($sformatf("cycle_dut1_t%0d", t_cyc), act1, model(t_cyc, P1, S1));
  end

  // ---------------- scoreboard pass over one full sequence ----------------
  // Called right after reset release; watches 80 cycles of dut0.
  task automatic pulse_pass(input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] cur_ad, win_ad;
    int   npulse, width;
    logic pw, pc, stable, csn_ok;
    npulse = 0; width = 0; pw = 1'b1; pc = 1'b1; stable = 1'b1; csn_ok = 1'b1;
    win_ad = '0;
    foreach (REF_TAB[i]) exp_q.push_back(REF_TAB[i]);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      cur_ad = {bus0.addr, bus0.data};
      if (pc && !bus0.CSN) begin
        win_ad = cur_ad;
        stable = 1'b1;
      end
      if (!bus0.CSN && (cur_ad !== win_ad)) stable = 1'b0;
      if (!pc && bus0.CSN) check({tag, "_csn_window_stable"}, stable, 1);
      if (pw && !bus0.WRN) begin
        npulse++;
        width  = 0;
        csn_ok = 1'b1;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL %s_extra_pulse: got pulse %0d expected none", tag, npulse);
        end else begin
          check({tag, "_pulse_addr_data"}, cur_ad, exp_q.pop_front());
        end
      end
      if (!bus0.WRN) begin
        width++;
        if (bus0.CSN) csn_ok = 1'b0;
      end
      if (!pw && bus0.WRN) begin
        check({tag, "_pulse_width"}, width, 2);
        check({tag, "_pulse_csn_low"}, csn_ok, 1);
      end
      pw = bus0.WRN;
      pc = bus0.CSN;
    end
    check({tag, "_pulse_count"}, npulse, 12);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          sel;
    int          t;
    logic [38:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cur;
    logic [38:0] act;

    vecs.push_back('{1'b0, 0,   mk(1, 1, 0, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b1, 0,   mk(1, 1, 0, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b1, 2,   mk(1, 1, 0, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b1, 3,   mk(1, 1, 1, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b1, 4,   mk(1, 1, 1, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b1, 5,   mk(1, 0, 1, 4'hF, 4'h0, 28'h007FC81)});
    vecs.push_back('{1'b1, 6,   mk(0, 0, 1, 4'hF, 4'h0, 28'h007FC81)});
    vecs.push_back('{1'b0, 9,   mk(1, 1, 0, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b0, 10,  mk(1, 1, 1, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b0, 19,  mk(1, 1, 1, 4'hF, 4'h0, 28'h0)});
    vecs.push_back('{1'b0, 20,  mk(1, 0, 1, 4'hF, 4'h0, 28'h007FC81)});
    vecs.push_back('{1'b0, 21,  mk(0, 0, 1, 4'hF, 4'h0, 28'h007FC81)});
    vecs.push_back('{1'b0, 22,  mk(0, 0, 1, 4'hF, 4'h0, 28'h007FC81)});
    vecs.push_back('{1'b0, 23,  mk(1, 1, 1, 4'hF, 4'h0, 28'h007FC81)});
    vecs.push_back('{1'b0, 24,  mk(1, 0, 1, 4'hF, 4'h1, 28'h0)});
    vecs.push_back('{1'b0, 48,  mk(1, 0, 1, 4'hF, 4'h7, 28'h0001FB4)});
    vecs.push_back('{1'b1, 52,  mk(1, 1, 1, 4'hF, 4'h4, 28'h6400000)});
    vecs.push_back('{1'b1, 53,  mk(1, 1, 1, 4'h0, 4'h0, 28'h0)});
    vecs.push_back('{1'b0, 62,  mk(0, 0, 1, 4'hF, 4'hE, 28'h0)});
    vecs.push_back('{1'b0, 65,  mk(0, 0, 1, 4'hF, 4'h4, 28'h6400000)});
    vecs.push_back('{1'b0, 67,  mk(1, 1, 1, 4'hF, 4'h4, 28'h6400000)});
    vecs.push_back('{1'b0, 68,  mk(1, 1, 1, 4'h0, 4'h0, 28'h0)});
    vecs.push_back('{1'b0, 250, mk(1, 1, 1, 4'h0, 4'h0, 28'h0)});

    // Reset held 10 cycles (the per-cycle monitor checks reset values).
    reset_n = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b1;

    cur = 0;
    foreach (vecs[i]) begin
      repeat (vecs[i].t - cur) @(negedge clk);
      cur = vecs[i].t;
      act = vecs[i].sel ? act1 : act0;
      check($sformatf("vec%0d_dut%0d_t%0d", i, vecs[i].sel, vecs[i].t), act, vecs[i].exp);
    end

    // Full sequence through the scoreboard.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pulse_pass("seq1");

    // One-cycle reset in the middle of write 5 (its first strobe cycle).
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (P0 + S0 + 4 * 5 + 1) @(negedge clk);
    check("mid_write_state", act0, mk(0, 0, 1, 4'hF, 4'h5, 28'h0));
    reset_n = 1'b0;
    @(negedge clk);
    check("abandon_reset", act0, mk(1, 1, 0, 4'hF, 4'h0, 28'h0));
    reset_n = 1'b1;
    pulse_pass("restart");

    // Random reset pulses at random points of the sequence.
    for (int r = 0; r < 6; r++) begin
      reset_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      reset_n = 1'b1;
      repeat ($urandom_range(0, 90)) @(negedge clk);
    end

    // Final run through to a long quiet DONE.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (260) @(negedge clk);
    check("final_done", act0, mk(1, 1, 1, 4'h0, 4'h0, 28'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
